nibble_serial_adder: RTL

NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/adder4_slice.sv | 17 +
 rtl/nibble_serial_adder.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared FSM state type and nibble width for the serial adder
package serial_adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/adder4_slice.sv
// rtl/adder4_slice.sv - 4-bit combinational adder slice with carry in/out
module adder4_slice
    import serial_adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                cout
);

    // Plain ripple of one nibble; the serial engine reuses this slice every cycle
    always_comb begin
        {cout, sum} = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, cin};
    end

endmodule

// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - nibble-serial adder, optional signed-overflow port under SERIAL_ADDER_OVF_EN
module nibble_serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    // WIDTH must be a multiple of 4 and at least 8, so there is always at least
    // one RUN cycle after the nibble handled at the handshake.
    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int CNT_W   = $clog2(NIBBLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIBBLES - 2);

    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;

    logic accept;
    logic last;

    logic [NIBBLE_W-1:0] nib_a;
    logic [NIBBLE_W-1:0] nib_b;
    logic                nib_cin;
    logic [NIBBLE_W-1:0] nib_sum;
    logic                nib_cout;

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_q, ovf_d;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs; the handshake cycle itself adds nibble 0,
    // RUN adds nibbles 1..NIBBLES-1, which puts out_valid NIBBLES cycles after accept
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        last      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cnt_q == CNT_LAST) begin
                    last    = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        accept  = 1'b1;
                        state_d = RUN;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Slice operands come straight from the ports on the accept cycle, else from the shifters
    always_comb begin
        nib_a   = accept ? a[NIBBLE_W-1:0] : a_q[NIBBLE_W-1:0];
        nib_b   = accept ? b[NIBBLE_W-1:0] : b_q[NIBBLE_W-1:0];
        nib_cin = accept ? cin : carry_q;
    end

    adder4_slice u_slice (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (nib_cin),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

    // Datapath next state: operands shift right, result fills from the top
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        if (accept) begin
            a_d     = a >> NIBBLE_W;
            b_d     = b >> NIBBLE_W;
            sum_d   = {nib_sum, sum_q[WIDTH-1:NIBBLE_W]};
            carry_d = nib_cout;
            cnt_d   = '0;
        end else if (state_q == RUN) begin
            a_d     = a_q >> NIBBLE_W;
            b_d     = b_q >> NIBBLE_W;
            sum_d   = {nib_sum, sum_q[WIDTH-1:NIBBLE_W]};
            carry_d = nib_cout;
            if (!last) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

    // After the last nibble the registered carry is the MSB carry-out
    assign sum  = sum_q;
    assign cout = carry_q;

`ifdef SERIAL_ADDER_OVF_EN
    // Carry into the MSB is recovered from the top sum bit; overflow is it XOR carry-out
    always_comb begin
        ovf_d = ovf_q;
        if (last) begin
            ovf_d = (nib_sum[NIBBLE_W-1] ^ nib_a[NIBBLE_W-1] ^ nib_b[NIBBLE_W-1]) ^ nib_cout;
        end
    end

    // Overflow flag register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule
